data_io_stream: RTL and testbench

- Parametrised successor to the MiST ARM-to-FPGA file-transfer block.
- Receives the io-controller SPI protocol on SPI_SS2, fully oversampled in clk_sys (no SPI-clock-domain logic).
- Packs download bytes into DW-bit words, buffers them in a FIFO and presents them on a valid/wait handshake instead of a clkref strobe.
- Supports uploads of DW-bit words with byte-lane serialisation; sits between the SPI pins and the core memory arbiter.

---
 rtl/data_io_stream.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_data_io_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_stream.sv
// SPI io-controller file transfer to a DW-bit valid/wait word stream.
// Optional download checksum: define DATA_IO_CHKSUM_EN.
module data_io_stream #(
  parameter int DW         = 8,
  parameter int AW         = 27,
  parameter int START_ADDR = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 2
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            SPI_SCK,
  input  logic            SPI_SS2,
  input  logic            SPI_DI,
  output logic            SPI_DO,
  output logic            ioctl_download,
  output logic            ioctl_upload,
  output logic [7:0]      ioctl_index,
  output logic [23:0]     ioctl_fileext,
  output logic [31:0]     ioctl_filesize,
  output logic            ioctl_wr,
  input  logic            ioctl_wait,
  output logic [AW-1:0]   ioctl_addr,
  output logic [DW-1:0]   ioctl_dout,
  output logic [DW/8-1:0] ioctl_be,
  output logic            ioctl_rd,
  input  logic [DW-1:0]   ioctl_din,
  output logic            ioctl_overflow,
  output logic [15:0]     ioctl_chksum
);
  localparam int NB = DW / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] SA  = AW'(START_ADDR);
  localparam logic [AW-1:0] INC = AW'(NB);
  localparam logic [LW-1:0] LL  = LW'(NB - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DL    = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_UP    = 2'd3;

  localparam logic [7:0] C_TX   = 8'h53;
  localparam logic [7:0] C_TXD  = 8'h54;
  localparam logic [7:0] C_IDX  = 8'h55;
  localparam logic [7:0] C_INFO = 8'h56;
  localparam logic [7:0] C_RX   = 8'h57;
  localparam logic [7:0] C_RXD  = 8'h58;

  logic [2:0]        sck_q, sck_d;
  logic [1:0]        ss_q, ss_d, di_q, di_d;
  logic [2:0]        bit_q, bit_d;
  logic [6:0]        sr_q, sr_d;
  logic              first_q, first_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [5:0]        pidx_q, pidx_d;
  logic [1:0]        state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [23:0]       ext_q, ext_d;
  logic [31:0]       size_q, size_d;
  logic [DW-1:0]     pk_q, pk_d;
  logic [NB-1:0]     pbe_q, pbe_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic              push_q, push_d;
  logic [AW-1:0]     daddr_q, daddr_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [AW-1:0]     uaddr_q, uaddr_d;
  logic [LW-1:0]     ulane_q, ulane_d;
  logic              rd_q, rd_d;
  logic [RD_LAT-1:0] rdp_q, rdp_d;
  logic              uok_q, uok_d;
  logic [DW-1:0]     uw_q, uw_d;
  logic [7:0]        osr_q, osr_d;
  logic              do_q, do_d;
`ifdef DATA_IO_CHKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  logic [AW-1:0] fa_q [FIFO_DEPTH];
  logic [DW-1:0] fd_q [FIFO_DEPTH];
  logic [NB-1:0] fb_q [FIFO_DEPTH];

  logic       sck_s, rise, fall, ss_s, di_s;
  logic       byte_done, pay, pop, full, wr_en;
  logic [7:0] rx, ob;

  assign sck_s = sck_q[1];
  assign rise  = sck_s & ~sck_q[2];
  assign fall  = ~sck_s & sck_q[2];
  assign ss_s  = ss_q[1];
  assign di_s  = di_q[1];
  assign rx    = {sr_q, di_s};
  assign byte_done = rise & ~ss_s & (bit_q == 3'd7);
  assign pay   = byte_done & ~first_q;
  assign pop   = (cnt_q != '0) & ~ioctl_wait;
  assign full  = cnt_q == (PW + 1)'(FIFO_DEPTH);
  assign wr_en = push_q & (~full | pop);

  // Next-state: SPI deframing, command handling, packer, FIFO, upload.
  always_comb begin
    sck_d = {sck_q[1:0], SPI_SCK};
    ss_d = {ss_q[0], SPI_SS2};
    di_d = {di_q[0], SPI_DI};
    bit_d = bit_q; sr_d = sr_q; first_d = first_q;
    cmd_d = cmd_q; pidx_d = pidx_q; state_d = state_q;
    idx_d = idx_q; ext_d = ext_q; size_d = size_q;
    pk_d = pk_q; pbe_d = pbe_q; lane_d = lane_q;
    push_d = 1'b0; daddr_d = daddr_q; ovf_d = ovf_q;
    uaddr_d = uaddr_q; ulane_d = ulane_q; rd_d = 1'b0;
    uok_d = uok_q; uw_d = uw_q; osr_d = osr_q; do_d = do_q;
    ob = 8'h00;
`ifdef DATA_IO_CHKSUM_EN
    sum_d = sum_q;
`endif
    cnt_d = cnt_q + (PW + 1)'(wr_en) - (PW + 1)'(pop);
    wp_d = wp_q + PW'(wr_en);
    rp_d = rp_q + PW'(pop);

    if (ss_s) begin
      bit_d = '0; first_d = 1'b1; pidx_d = '0;
    end else if (rise) begin
      bit_d = bit_q + 3'd1;
      sr_d = {sr_q[5:0], di_s};
      if (bit_q == 3'd7) begin
        first_d = 1'b0;
        if (first_q) cmd_d = rx;
        else if (pidx_q != '1) pidx_d = pidx_q + 6'd1;
      end
    end

    // A completed word enters the FIFO, or is lost if no room.
    if (push_q) begin
      daddr_d = daddr_q + INC;
      pk_d = '0; pbe_d = '0;
      if (full & ~pop) ovf_d = 1'b1;
    end

    if (state_q == S_DRAIN && cnt_q == '0 && !push_q)
      state_d = S_IDLE;

    if (pay) begin
      unique case (cmd_q)
        C_TX:
          if (rx[0]) begin
            state_d = S_DL; pk_d = '0; pbe_d = '0;
            lane_d = '0; ovf_d = 1'b0; daddr_d = SA;
`ifdef DATA_IO_CHKSUM_EN
            sum_d = '0;
`endif
          end else if (state_q == S_DL) begin
            push_d = pbe_q != '0;
            lane_d = '0;
            state_d = S_DRAIN;
          end
        C_TXD:
          if (state_q == S_DL) begin
            pk_d[lane_q*8 +: 8] = rx;
            pbe_d[lane_q] = 1'b1;
`ifdef DATA_IO_CHKSUM_EN
            sum_d = sum_q + {8'h00, rx};
`endif
            if (lane_q == LL) begin
              push_d = 1'b1; lane_d = '0;
            end else begin
              lane_d = lane_q + LW'(1);
            end
          end
        C_IDX:
          if (pidx_q == '0) idx_d = rx;
        C_INFO:
          unique case (pidx_q)
            6'h08: ext_d[23:16] = rx;
            6'h09: ext_d[15:8]  = rx;
            6'h0A: ext_d[7:0]   = rx;
            6'h1C: size_d[7:0]   = rx;
            6'h1D: size_d[15:8]  = rx;
            6'h1E: size_d[23:16] = rx;
            6'h1F: size_d[31:24] = rx;
            default: ;
          endcase
        C_RX:
          if (rx[0]) begin
            if (state_q == S_IDLE) begin
              state_d = S_UP; uaddr_d = SA;
              ulane_d = '0; rd_d = 1'b1;
            end
          end else if (state_q == S_UP) begin
            state_d = S_IDLE;
          end
        default: ;
      endcase
    end

    rdp_d = rdp_q << 1;
    rdp_d[0] = rd_q;
    if (rd_q) uok_d = 1'b0;
    if (rdp_q[RD_LAT-1]) begin
      uw_d = ioctl_din; uok_d = 1'b1;
    end

    // Outgoing byte is chosen at its first SCK fall, MSB first.
    if (ss_s) begin
      osr_d = '0; do_d = 1'b0;
    end else if (fall) begin
      if (bit_q == 3'd0 && !first_q) begin
        if (cmd_q == C_RXD && state_q == S_UP) begin
          if (uok_q) ob = uw_q[ulane_q*8 +: 8];
          if (ulane_q == LL) begin
            ulane_d = '0; uaddr_d = uaddr_q + INC; rd_d = 1'b1;
          end else begin
            ulane_d = ulane_q + LW'(1);
          end
        end
        osr_d = {ob[6:0], 1'b0}; do_d = ob[7];
      end else begin
        do_d = osr_q[7]; osr_d = {osr_q[6:0], 1'b0};
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sck_q <= '0; ss_q <= '1; di_q <= '0;
      bit_q <= '0; sr_q <= '0; first_q <= 1'b1;
      cmd_q <= '0; pidx_q <= '0; state_q <= S_IDLE;
      idx_q <= '0; ext_q <= '0; size_q <= '0;
      pk_q <= '0; pbe_q <= '0; lane_q <= '0;
      push_q <= 1'b0; daddr_q <= '0; ovf_q <= 1'b0;
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
      uaddr_q <= '0; ulane_q <= '0; rd_q <= 1'b0;
      rdp_q <= '0; uok_q <= 1'b0; uw_q <= '0;
      osr_q <= '0; do_q <= 1'b0;
`ifdef DATA_IO_CHKSUM_EN
      sum_q <= '0;
`endif
    end else begin
      sck_q <= sck_d; ss_q <= ss_d; di_q <= di_d;
      bit_q <= bit_d; sr_q <= sr_d; first_q <= first_d;
      cmd_q <= cmd_d; pidx_q <= pidx_d; state_q <= state_d;
      idx_q <= idx_d; ext_q <= ext_d; size_q <= size_d;
      pk_q <= pk_d; pbe_q <= pbe_d; lane_q <= lane_d;
      push_q <= push_d; daddr_q <= daddr_d; ovf_q <= ovf_d;
      wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d;
      uaddr_q <= uaddr_d; ulane_q <= ulane_d; rd_q <= rd_d;
      rdp_q <= rdp_d; uok_q <= uok_d; uw_q <= uw_d;
      osr_q <= osr_d; do_q <= do_d;
`ifdef DATA_IO_CHKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end

  // FIFO storage; contents are masked at the outputs while empty.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      fa_q[wp_q] <= daddr_q;
      fd_q[wp_q] <= pk_q;
      fb_q[wp_q] <= pbe_q;
    end
  end

  assign SPI_DO = SPI_SS2 ? 1'bz : do_q;
  assign ioctl_download = (state_q == S_DL) || (state_q == S_DRAIN);
  assign ioctl_upload = state_q == S_UP;
  assign ioctl_index = idx_q;
  assign ioctl_fileext = ext_q;
  assign ioctl_filesize = size_q;
  assign ioctl_wr = cnt_q != '0;
  assign ioctl_addr = ioctl_upload ? uaddr_q :
                      ioctl_wr ? fa_q[rp_q] : '0;
  assign ioctl_dout = ioctl_wr ? fd_q[rp_q] : '0;
  assign ioctl_be = ioctl_wr ? fb_q[rp_q] : '0;
  assign ioctl_rd = rd_q;
  assign ioctl_overflow = ovf_q;
`ifdef DATA_IO_CHKSUM_EN
  assign ioctl_chksum = sum_q;
`else
  assign ioctl_chksum = 16'h0000;
`endif
endmodule

// File: tb/tb_data_io_stream.sv
// Directed bench for data_io_stream (DW=16, FIFO_DEPTH=2).
// SPI master runs at exactly clk_sys/4.
module tb_data_io_stream;
  localparam int DW = 16;
  localparam int AW = 27;

  logic clk = 0;
  logic reset = 1;
  logic SPI_SCK = 0, SPI_SS2 = 1, SPI_DI = 0;
  wire  SPI_DO;
  logic ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
  logic ioctl_wait = 0;
  logic [7:0] ioctl_index;
  logic [23:0] ioctl_fileext;
  logic [31:0] ioctl_filesize;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout, ioctl_din;
  logic [1:0] ioctl_be;
  logic ioctl_overflow;
  logic [15:0] ioctl_chksum;

  data_io_stream #(.DW(DW), .AW(AW), .FIFO_DEPTH(2)) dut (
    .clk_sys(clk), .reset(reset),
    .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2),
    .SPI_DI(SPI_DI), .SPI_DO(SPI_DO),
    .ioctl_download(ioctl_download),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_fileext(ioctl_fileext),
    .ioctl_filesize(ioctl_filesize),
    .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_be(ioctl_be), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din),
    .ioctl_overflow(ioctl_overflow),
    .ioctl_chksum(ioctl_chksum)
  );

  always #5 clk = ~clk;

  // Upload source: word content depends on the requested address.
  assign ioctl_din = ioctl_addr[1] ? 16'hC2D3 : 16'hA0B1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    be;
  } wd_t;

  int tests = 0;
  int fails = 0;
  int stab_bad = 0;
  wd_t got[$];
  logic [AW-1:0] rda[$];
  logic [7:0] txq[$], rxq[$];
  logic pw = 0;
  wd_t pv;
  logic rnd;

  // Record accepted words and read requests; flag changes under wait.
  always @(negedge clk) begin
    if (ioctl_wr && !ioctl_wait)
      got.push_back('{ioctl_addr, ioctl_dout, ioctl_be});
    if (ioctl_rd) rda.push_back(ioctl_addr);
    if (pw && (!ioctl_wr || pv != wd_t'({ioctl_addr, ioctl_dout, ioctl_be})))
      stab_bad++;
    pw = ioctl_wr && ioctl_wait;
    pv = '{ioctl_addr, ioctl_dout, ioctl_be};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbyte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SPI_SCK = 0; SPI_DI = tx[i];
      clks(2);
      SPI_SCK = 1;
      clks(2);
      rx[i] = SPI_DO;
    end
  endtask

  task automatic xfer(input logic [7:0] cmd);
    logic [7:0] r;
    rxq = {};
    SPI_SS2 = 0; clks(4);
    sbyte(cmd, r);
    foreach (txq[i]) begin
      sbyte(txq[i], r);
      rxq.push_back(r);
    end
    clks(2); SPI_SS2 = 1; clks(4);
    SPI_SCK = 0; clks(4);
  endtask

  task automatic tx1(input logic [7:0] cmd, input logic [7:0] b);
    txq = {b};
    xfer(cmd);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ck_a, ck_b;
`ifdef DATA_IO_CHKSUM_EN
    ck_a = 16'h0015; ck_b = 16'h0200;
`else
    ck_a = 16'h0000; ck_b = 16'h0000;
`endif
    clks(4);
    reset = 0;
    clks(1);
    chk("rst_wr", ioctl_wr, 0);
    chk("rst_dl", ioctl_download, 0);
    chk("rst_ul", ioctl_upload, 0);
    chk("rst_addr", ioctl_addr, 0);
    chk("rst_rd", ioctl_rd, 0);
    chk("rst_ovf", ioctl_overflow, 0);
    chk("rst_ck", ioctl_chksum, 0);

    tx1(8'h55, 8'h07);
    chk("index", ioctl_index, 8'h07);

    txq = {};
    for (int i = 0; i < 32; i++) txq.push_back(8'h00);
    txq[8] = 8'h52; txq[9] = 8'h4F; txq[10] = 8'h4D;
    txq[28] = 8'h45; txq[29] = 8'h23;
    txq[30] = 8'h01; txq[31] = 8'h00;
    xfer(8'h56);
    chk("fileext", ioctl_fileext, 24'h524F4D);
    chk("filesize", ioctl_filesize, 32'h00012345);

    got = {};
    tx1(8'h53, 8'h01);
    chk("dl_on", ioctl_download, 1);
    txq = {8'h11, 8'h22, 8'h33};
    xfer(8'h54);
    tx1(8'h53, 8'h00);
    clks(10);
    chk("dl_n", got.size(), 2);
    chk("dl_w0", got[0], {27'd0, 16'h2211, 2'b11});
    chk("dl_w1", got[1], {27'd2, 16'h0033, 2'b01});
    chk("dl_off", ioctl_download, 0);

    ioctl_wait = 1;
    got = {};
    tx1(8'h53, 8'h01);
    txq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    xfer(8'h54);
    chk("ov_flag", ioctl_overflow, 1);
    chk("ov_wr", ioctl_wr, 1);
    chk("ov_head", {ioctl_addr, ioctl_dout, ioctl_be}, {27'd0, 16'h0201, 2'b11});
    chk("ov_ck", ioctl_chksum, ck_a);
    clks(5);
    chk("ov_hold", ioctl_dout, 16'h0201);
    tx1(8'h53, 8'h00);
    chk("ov_drain", ioctl_download, 1);
    ioctl_wait = 0;
    clks(6);
    chk("ov_n", got.size(), 2);
    chk("ov_a0", got[0].a, 0);
    chk("ov_a1", {got[1].a, got[1].d}, {27'd2, 16'h0403});
    chk("ov_dl", ioctl_download, 0);
    chk("ov_sticky", ioctl_overflow, 1);
    tx1(8'h53, 8'h01);
    chk("ov_clr", ioctl_overflow, 0);
    chk("ck_clr", ioctl_chksum, 0);
    tx1(8'h53, 8'h00);
    clks(10);

    tx1(8'h53, 8'h01);
    txq = {8'hFF, 8'hFF, 8'h02};
    xfer(8'h54);
    chk("chksum", ioctl_chksum, ck_b);
    tx1(8'h53, 8'h00);
    clks(10);

    got = {};
    stab_bad = 0;
    tx1(8'h53, 8'h01);
    txq = {};
    for (int i = 0; i < 32; i++) txq.push_back(8'(8'h40 + i));
    rnd = 1;
    fork
      begin xfer(8'h54); rnd = 0; end
      begin
        while (rnd) begin
          @(posedge clk);
          #1 ioctl_wait = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    ioctl_wait = 0;
    tx1(8'h53, 8'h00);
    clks(10);
    chk("rw_n", got.size(), 16);
    for (int k = 0; k < 16; k++) begin
      logic [7:0] lo, hi;
      lo = 8'(8'h40 + 2 * k);
      hi = 8'(8'h41 + 2 * k);
      chk($sformatf("rw_w%0d", k), got[k], {27'(2 * k), hi, lo, 2'b11});
    end
    chk("rw_stable", stab_bad, 0);
    chk("rw_ovf", ioctl_overflow, 0);

    rda = {};
    tx1(8'h57, 8'h01);
    chk("ul_on", ioctl_upload, 1);
    clks(4);
    txq = {8'h00, 8'h00, 8'h00};
    xfer(8'h58);
    chk("ul_b0", rxq[0], 8'hB1);
    chk("ul_b1", rxq[1], 8'hA0);
    chk("ul_b2", rxq[2], 8'hD3);
    chk("ul_nrd", rda.size(), 2);
    chk("ul_rd0", rda[0], 0);
    chk("ul_rd1", rda[1], 2);
    tx1(8'h57, 8'h00);
    chk("ul_off", ioctl_upload, 0);

    tx1(8'h53, 8'h01);
    ioctl_wait = 1;
    txq = {8'hAA, 8'hBB};
    xfer(8'h54);
    chk("mr_wr", ioctl_wr, 1);
    reset = 1;
    clks(1);
    chk("mr_wr0", ioctl_wr, 0);
    chk("mr_dl0", ioctl_download, 0);
    chk("mr_out", {ioctl_addr, ioctl_dout, ioctl_be}, 0);
    chk("mr_info", {ioctl_index, ioctl_fileext, ioctl_filesize}, 0);
    reset = 0;
    ioctl_wait = 0;
    clks(4);
    chk("mr_empty", ioctl_wr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
